// File: rtl/tile_map_engine.sv
// tile_map_engine: MAP_W x MAP_H tile-code RAM with a registered render lookup port,
// SoC layout loads, a power-on/clear sweep and bullet-hit resolution with sticky base flags.
// Build option: define TILE_HP_EN to give destructible walls per-cell hit points (WALL_HP).
module tile_map_engine #(
    parameter int unsigned MAP_W      = 20,
    parameter int unsigned MAP_H      = 15,
    parameter int unsigned TILE_SHIFT = 5,
    parameter int unsigned TILE_BITS  = 3,
    parameter int unsigned WALL_HP    = 2
) (
    input  logic                                Clk,
    input  logic                                Reset_n,
    input  logic [9:0]                          DrawX,
    input  logic [9:0]                          DrawY,
    output logic [TILE_BITS-1:0]                TileCode,
    input  logic                                load_we,
    input  logic [$clog2(MAP_W*MAP_H)-1:0]      load_addr,
    input  logic [TILE_BITS-1:0]                load_data,
    output logic                                load_ready,
    input  logic                                clear_start,
    input  logic                                hit_req,
    input  logic [9:0]                          hit_x,
    input  logic [9:0]                          hit_y,
    output logic                                hit_ready,
    output logic                                hit_done,
    output logic [1:0]                          hit_result,
    output logic [1:0]                          base_destroyed,
    output logic                                busy
);

    localparam int unsigned N_CELLS = MAP_W * MAP_H;
    localparam int unsigned AW      = $clog2(N_CELLS);
    localparam int unsigned SXW     = $clog2(MAP_W);
    localparam int unsigned SYW     = $clog2(MAP_H);

    localparam logic [TILE_BITS-1:0] T_EMPTY  = TILE_BITS'(0);
    localparam logic [TILE_BITS-1:0] T_BORDER = TILE_BITS'(1);
    localparam logic [TILE_BITS-1:0] T_WALL   = TILE_BITS'(2);
    localparam logic [TILE_BITS-1:0] T_BASE1  = TILE_BITS'(3);
    localparam logic [TILE_BITS-1:0] T_BASE2  = TILE_BITS'(4);

    localparam logic [1:0] R_EMPTY     = 2'b00;
    localparam logic [1:0] R_BLOCKED   = 2'b01;
    localparam logic [1:0] R_DAMAGED   = 2'b10;
    localparam logic [1:0] R_DESTROYED = 2'b11;

    // A wall that needs zero hits is meaningless; reject such a configuration at elaboration.
    if (WALL_HP == 0) begin : g_hp_check
        $error("tile_map_engine: WALL_HP must be at least 1");
    end

`ifdef TILE_HP_EN
    localparam int unsigned    HPW     = $clog2(WALL_HP + 1);
    localparam logic [HPW-1:0] HP_FULL = HPW'(WALL_HP);
`endif

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_IDLE   = 2'd1,
        S_HIT_RD = 2'd2,
        S_HIT_WR = 2'd3
    } state_e;

    // Pixel coordinate to tile out-of-range test.
    function automatic logic cell_oob(input logic [9:0] x, input logic [9:0] y);
        return ((32'(x) >> TILE_SHIFT) >= MAP_W) || ((32'(y) >> TILE_SHIFT) >= MAP_H);
    endfunction

    // Pixel coordinate to linear cell index (meaningful only when in range).
    function automatic logic [AW-1:0] cell_idx(input logic [9:0] x, input logic [9:0] y);
        logic [31:0] tx;
        logic [31:0] ty;
        tx = 32'(x) >> TILE_SHIFT;
        ty = 32'(y) >> TILE_SHIFT;
        return AW'(ty * MAP_W + tx);
    endfunction

    logic [TILE_BITS-1:0] tile_mem [N_CELLS];
`ifdef TILE_HP_EN
    logic [HPW-1:0]       hp_mem   [N_CELLS];
    logic [HPW-1:0]       h_hp;
    logic [HPW-1:0]       wr_hp_q, wr_hp_d;
    logic [HPW-1:0]       mem_whp;
`endif

    state_e               state_q, state_d;
    logic [AW-1:0]        sweep_q, sweep_d;
    logic [SXW-1:0]       sx_q, sx_d;
    logic [SYW-1:0]       sy_q, sy_d;
    logic [9:0]           hx_q, hx_d;
    logic [9:0]           hy_q, hy_d;
    logic                 hit_done_q, hit_done_d;
    logic [1:0]           hit_result_q, hit_result_d;
    logic [1:0]           base_q, base_d;
    logic                 busy_q, busy_d;
    logic                 hit_ready_q, hit_ready_d;
    logic                 load_ready_q, load_ready_d;
    logic                 wr_pend_q, wr_pend_d;
    logic [TILE_BITS-1:0] wr_code_q, wr_code_d;
    logic [TILE_BITS-1:0] tile_code_q;

    logic                 rd_oob;
    logic [AW-1:0]        rd_idx;
    logic                 h_oob;
    logic [AW-1:0]        h_idx;
    logic [TILE_BITS-1:0] h_code;
    logic                 edge_cell;
    logic                 mem_we;
    logic [AW-1:0]        mem_wa;
    logic [TILE_BITS-1:0] mem_wd;

    assign rd_oob = cell_oob(DrawX, DrawY);
    assign rd_idx = cell_idx(DrawX, DrawY);
    assign h_oob  = cell_oob(hx_q, hy_q);
    assign h_idx  = cell_idx(hx_q, hy_q);
    assign h_code = h_oob ? T_BORDER : tile_mem[h_idx];
`ifdef TILE_HP_EN
    assign h_hp   = hp_mem[h_idx];
`endif
    assign edge_cell = (sx_q == '0) || (sx_q == SXW'(MAP_W - 1)) ||
                       (sy_q == '0) || (sy_q == SYW'(MAP_H - 1));

    // Next-state, hit resolution and RAM write-port selection.
    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        hx_d         = hx_q;
        hy_d         = hy_q;
        hit_done_d   = 1'b0;
        hit_result_d = hit_result_q;
        base_d       = base_q;
        wr_pend_d    = 1'b0;
        wr_code_d    = wr_code_q;
        mem_we       = 1'b0;
        mem_wa       = '0;
        mem_wd       = T_EMPTY;
`ifdef TILE_HP_EN
        wr_hp_d      = wr_hp_q;
        mem_whp      = HP_FULL;
`endif

        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = sweep_q;
                mem_wd = edge_cell ? T_BORDER : T_EMPTY;
                if (sweep_q == AW'(N_CELLS - 1)) begin
                    state_d = S_IDLE;
                    sweep_d = '0;
                    sx_d    = '0;
                    sy_d    = '0;
                end else begin
                    sweep_d = sweep_q + AW'(1);
                    if (sx_q == SXW'(MAP_W - 1)) begin
                        sx_d = '0;
                        sy_d = sy_q + SYW'(1);
                    end else begin
                        sx_d = sx_q + SXW'(1);
                    end
                end
            end
            S_IDLE: begin
                if (clear_start) begin
                    state_d = S_CLEAR;
                    base_d  = 2'b00;
                    sweep_d = '0;
                    sx_d    = '0;
                    sy_d    = '0;
                end else if (hit_req) begin
                    state_d = S_HIT_RD;
                    hx_d    = hit_x;
                    hy_d    = hit_y;
                end else if (load_we && (32'(load_addr) < N_CELLS)) begin
                    mem_we = 1'b1;
                    mem_wa = load_addr;
                    mem_wd = load_data;
                end
            end
            S_HIT_RD: begin
                state_d    = S_HIT_WR;
                hit_done_d = 1'b1;
                case (h_code)
                    T_EMPTY: hit_result_d = R_EMPTY;
                    T_WALL: begin
`ifdef TILE_HP_EN
                        if (h_hp <= HPW'(1)) begin
                            hit_result_d = R_DESTROYED;
                            wr_pend_d    = 1'b1;
                            wr_code_d    = T_EMPTY;
                            wr_hp_d      = '0;
                        end else begin
                            hit_result_d = R_DAMAGED;
                            wr_pend_d    = 1'b1;
                            wr_code_d    = T_WALL;
                            wr_hp_d      = h_hp - HPW'(1);
                        end
`else
                        hit_result_d = R_DESTROYED;
                        wr_pend_d    = 1'b1;
                        wr_code_d    = T_EMPTY;
`endif
                    end
                    T_BASE1: begin
                        hit_result_d = R_DESTROYED;
                        wr_pend_d    = 1'b1;
                        wr_code_d    = T_EMPTY;
                        base_d[0]    = 1'b1;
                    end
                    T_BASE2: begin
                        hit_result_d = R_DESTROYED;
                        wr_pend_d    = 1'b1;
                        wr_code_d    = T_EMPTY;
                        base_d[1]    = 1'b1;
                    end
                    default: hit_result_d = R_BLOCKED;
                endcase
            end
            S_HIT_WR: begin
                state_d = S_IDLE;
                if (wr_pend_q) begin
                    mem_we = 1'b1;
                    mem_wa = h_idx;
                    mem_wd = wr_code_q;
`ifdef TILE_HP_EN
                    mem_whp = wr_hp_q;
`endif
                end
            end
            default: state_d = S_CLEAR;
        endcase

        busy_d       = (state_d == S_CLEAR);
        hit_ready_d  = (state_d == S_IDLE);
        load_ready_d = (state_d == S_IDLE);
    end

    // Control and output registers; reset aborts any hit or sweep in progress.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_CLEAR;
            sweep_q      <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            hx_q         <= '0;
            hy_q         <= '0;
            hit_done_q   <= 1'b0;
            hit_result_q <= R_EMPTY;
            base_q       <= 2'b00;
            busy_q       <= 1'b1;
            hit_ready_q  <= 1'b0;
            load_ready_q <= 1'b0;
            wr_pend_q    <= 1'b0;
            wr_code_q    <= T_EMPTY;
`ifdef TILE_HP_EN
            wr_hp_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            hx_q         <= hx_d;
            hy_q         <= hy_d;
            hit_done_q   <= hit_done_d;
            hit_result_q <= hit_result_d;
            base_q       <= base_d;
            busy_q       <= busy_d;
            hit_ready_q  <= hit_ready_d;
            load_ready_q <= load_ready_d;
            wr_pend_q    <= wr_pend_d;
            wr_code_q    <= wr_code_d;
`ifdef TILE_HP_EN
            wr_hp_q      <= wr_hp_d;
`endif
        end
    end

    // Render lookup; a same-cycle write to the cell is seen only on the next lookup.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tile_code_q <= T_EMPTY;
        end else begin
            tile_code_q <= rd_oob ? T_BORDER : tile_mem[rd_idx];
        end
    end

    // Single shared write port for the tile (and HP) storage.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            tile_mem[mem_wa] <= mem_wd;
`ifdef TILE_HP_EN
            hp_mem[mem_wa]   <= mem_whp;
`endif
        end
    end

    assign TileCode       = tile_code_q;
    assign hit_done       = hit_done_q;
    assign hit_result     = hit_result_q;
    assign base_destroyed = base_q;
    assign busy           = busy_q;
    assign hit_ready      = hit_ready_q;
    assign load_ready     = load_ready_q;

endmodule

// File: tb/tb_tile_map_engine.sv
// tb_tile_map_engine: directed, table-driven bench for tile_map_engine (default 20x15 map).
module tb_tile_map_engine;

    localparam int unsigned N_CELLS = 300;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [9:0] DrawX, DrawY;
    logic [2:0] TileCode;
    logic       load_we;
    logic [8:0] load_addr;
    logic [2:0] load_data;
    logic       load_ready;
    logic       clear_start;
    logic       hit_req;
    logic [9:0] hit_x, hit_y;
    logic       hit_ready, hit_done;
    logic [1:0] hit_result, base_destroyed;
    logic       busy;

    int checks = 0;
    int errors = 0;

    tile_map_engine dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .TileCode       (TileCode),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .clear_start    (clear_start),
        .hit_req        (hit_req),
        .hit_x          (hit_x),
        .hit_y          (hit_y),
        .hit_ready      (hit_ready),
        .hit_done       (hit_done),
        .hit_result     (hit_result),
        .base_destroyed (base_destroyed),
        .busy           (busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] exp_code;
    } rvec_t;

    rvec_t rv [10];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic render(input logic [9:0] x, input logic [9:0] y, input logic [2:0] exp, input string name);
        DrawX = x;
        DrawY = y;
        tick();
        check(name, 32'(TileCode), 32'(exp));
    endtask

    task automatic load(input logic [8:0] a, input logic [2:0] d);
        load_addr = a;
        load_data = d;
        load_we   = 1'b1;
        tick();
        load_we   = 1'b0;
    endtask

    // Counts cycles until busy falls; caller compares against the sweep length.
    task automatic count_busy(output int n, output int done_seen);
        n = 0;
        done_seen = 0;
        do begin
            tick();
            n++;
            if (hit_done) done_seen = 1;
        end while (busy && n < 1000);
    endtask

    task automatic do_hit(input logic [9:0] x, input logic [9:0] y, input logic [1:0] exp, input string name);
        int n;
        n = 0;
        while (!hit_ready && n < 50) begin
            tick();
            n++;
        end
        check({name, " ready"}, 32'(hit_ready), 32'd1);
        hit_x   = x;
        hit_y   = y;
        hit_req = 1'b1;
        tick();
        hit_req = 1'b0;
        check({name, " rd_ready"}, 32'(hit_ready), 32'd0);
        check({name, " rd_done"}, 32'(hit_done), 32'd0);
        tick();
        check({name, " done"}, 32'(hit_done), 32'd1);
        check({name, " result"}, 32'(hit_result), 32'(exp));
        tick();
        check({name, " pulse_end"}, 32'(hit_done), 32'd0);
    endtask

    initial begin
        int n;
        int seen;

        rv[0] = '{x: 10'd0,   y: 10'd0,   exp_code: 3'd1};
        rv[1] = '{x: 10'd40,  y: 10'd40,  exp_code: 3'd0};
        rv[2] = '{x: 10'd639, y: 10'd0,   exp_code: 3'd1};
        rv[3] = '{x: 10'd608, y: 10'd448, exp_code: 3'd1};
        rv[4] = '{x: 10'd700, y: 10'd100, exp_code: 3'd1};
        rv[5] = '{x: 10'd100, y: 10'd479, exp_code: 3'd1};
        rv[6] = '{x: 10'd320, y: 10'd240, exp_code: 3'd0};
        rv[7] = '{x: 10'd0,   y: 10'd200, exp_code: 3'd1};
        rv[8] = '{x: 10'd600, y: 10'd200, exp_code: 3'd0};
        rv[9] = '{x: 10'd100, y: 10'd480, exp_code: 3'd1};

        Reset_n = 1'b0; DrawX = '0; DrawY = '0; load_we = 1'b0; load_addr = '0; load_data = '0;
        clear_start = 1'b0; hit_req = 1'b0; hit_x = '0; hit_y = '0;

        // Reset values
        tick(); tick();
        check("rst busy",       32'(busy),           32'd1);
        check("rst hit_ready",  32'(hit_ready),      32'd0);
        check("rst load_ready", 32'(load_ready),     32'd0);
        check("rst hit_done",   32'(hit_done),       32'd0);
        check("rst hit_result", 32'(hit_result),     32'd0);
        check("rst base",       32'(base_destroyed), 32'd0);
        check("rst tilecode",   32'(TileCode),       32'd0);
        Reset_n = 1'b1;
        count_busy(n, seen);
        check("reset sweep len", 32'(n), 32'(N_CELLS));
        check("idle hit_ready",  32'(hit_ready),  32'd1);
        check("idle load_ready", 32'(load_ready), 32'd1);

        // Render lookups over the cleared map
        for (int i = 0; i < 10; i++) begin
            render(rv[i].x, rv[i].y, rv[i].exp_code, $sformatf("render vec%0d", i));
        end

        // Destructible wall at tile (1,1)
        load(9'd21, 3'd2);
        render(10'd40, 10'd40, 3'd2, "load wall");
`ifdef TILE_HP_EN
        do_hit(10'd40, 10'd40, 2'b10, "wall hit1");
        render(10'd40, 10'd40, 3'd2, "wall damaged");
        do_hit(10'd40, 10'd40, 2'b11, "wall hit2");
`else
        do_hit(10'd40, 10'd40, 2'b11, "wall hit1");
`endif
        render(10'd40, 10'd40, 3'd0, "wall gone");

        // P2 base at tile (9,1), then P1 base at tile (2,1)
        load(9'd29, 3'd4);
        do_hit(10'd290, 10'd40, 2'b11, "p2 base hit");
        check("p2 flag", 32'(base_destroyed), 32'd2);
        do_hit(10'd290, 10'd40, 2'b00, "p2 rehit");
        check("p2 flag sticky", 32'(base_destroyed), 32'd2);
        load(9'd22, 3'd3);
        do_hit(10'd70, 10'd40, 2'b11, "p1 base hit");
        check("both flags", 32'(base_destroyed), 32'd3);

        // Blocked cases: off-map, border, alias code 6
        do_hit(10'd700, 10'd100, 2'b01, "oob hit");
        do_hit(10'd0, 10'd0, 2'b01, "border hit");
        render(10'd0, 10'd0, 3'd1, "border kept");
        load(9'd23, 3'd6);
        do_hit(10'd100, 10'd40, 2'b01, "code6 hit");
        render(10'd100, 10'd40, 3'd6, "code6 kept");

        // Hit wins over same-cycle load; loads dropped during the hit
        load_addr = 9'd24; load_data = 3'd3; load_we = 1'b1;
        hit_x = 10'd40; hit_y = 10'd40; hit_req = 1'b1;
        tick();
        hit_req = 1'b0; load_we = 1'b0;
        check("prio rd load_ready", 32'(load_ready), 32'd0);
        load_addr = 9'd25; load_data = 3'd4; load_we = 1'b1;
        tick();
        check("prio wr load_ready", 32'(load_ready), 32'd0);
        check("prio done",   32'(hit_done),   32'd1);
        check("prio result", 32'(hit_result), 32'd0);
        tick();
        load_we = 1'b0;
        check("prio pulse_end", 32'(hit_done), 32'd0);
        render(10'd130, 10'd40, 3'd0, "dropped load 24");
        render(10'd160, 10'd40, 3'd0, "dropped load 25");

        // Render of the cell being written in HIT_WR returns the old code
        load(9'd26, 3'd3);
        hit_x = 10'd200; hit_y = 10'd40; hit_req = 1'b1;
        tick();
        hit_req = 1'b0;
        tick();
        check("rw done", 32'(hit_done), 32'd1);
        DrawX = 10'd200; DrawY = 10'd40;
        tick();
        check("rw old value", 32'(TileCode), 32'd3);
        tick();
        check("rw new value", 32'(TileCode), 32'd0);

        // Reset during HIT_RD aborts the hit and restarts the sweep
        load(9'd27, 3'd4);
        hit_x = 10'd230; hit_y = 10'd40; hit_req = 1'b1;
        tick();
        hit_req = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("abort done",  32'(hit_done),       32'd0);
        check("abort base",  32'(base_destroyed), 32'd0);
        check("abort busy",  32'(busy),           32'd1);
        tick(); tick();
        Reset_n = 1'b1;
        count_busy(n, seen);
        check("abort sweep len",  32'(n),    32'(N_CELLS));
        check("abort no done",    32'(seen), 32'd0);
        check("abort base after", 32'(base_destroyed), 32'd0);
        render(10'd230, 10'd40, 3'd0, "abort cell cleared");

        // clear_start in IDLE re-runs the sweep and drops base flags
        load(9'd28, 3'd3);
        do_hit(10'd260, 10'd40, 2'b11, "p1 before clear");
        check("flag before clear", 32'(base_destroyed), 32'd1);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        check("clear busy",  32'(busy),           32'd1);
        check("clear base",  32'(base_destroyed), 32'd0);
        check("clear ready", 32'(hit_ready),      32'd0);
        count_busy(n, seen);
        check("clear sweep len", 32'(n), 32'(N_CELLS));
        render(10'd0, 10'd0, 3'd1, "post clear border");
        render(10'd100, 10'd40, 3'd0, "post clear code6 gone");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_map_engine.md
Name: tile_map_engine

Overview:
- Parametrised, stateful successor to the fixed 20x15 constant tile map.
- Holds an MAP_W x MAP_H grid of tile codes in on-chip RAM.
- Serves per-pixel tile lookups to the colour mapper, accepts layout writes from the SoC, and resolves bullet hits against destructible walls and bases.
- Raises sticky base-destroyed flags for game logic.

Parameters:
MAP_W, 20, tiles per row
MAP_H, 15, tiles per column
TILE_SHIFT, 5, log2 of tile edge in pixels (32 px)
TILE_BITS, 3, tile code width
WALL_HP, 2, hits needed to destroy a destructible wall (only used with TILE_HP_EN)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
DrawX  in  10  render pixel x
DrawY  in  10  render pixel y
TileCode  out  TILE_BITS  tile code at (DrawX,DrawY), registered
load_we  in  1  layout write strobe
load_addr  in  clog2(MAP_W*MAP_H)  linear cell index
load_data  in  TILE_BITS  tile code to write
load_ready  out  1  high when a load write will be accepted
clear_start  in  1  pulse: re-run the clear sweep
hit_req  in  1  hit request
hit_x  in  10  hit pixel x
hit_y  in  10  hit pixel y
hit_ready  out  1  hit request accepted this cycle if hit_req is high
hit_done  out  1  one-cycle pulse, result valid
hit_result  out  2  00 empty, 01 blocked, 10 damaged, 11 destroyed
base_destroyed  out  2  [0] P1 base, [1] P2 base; sticky
busy  out  1  clear sweep in progress

Behaviour:
- Tile codes: 0 empty, 1 border (unbreakable), 2 destructible wall, 3 P1 base, 4 P2 base; codes 5..7 are treated as 1.
- Cell index: idx = ty*MAP_W + tx, with tx = x>>TILE_SHIFT and ty = y>>TILE_SHIFT.
- Out-of-range cell (tx>=MAP_W or ty>=MAP_H): TileCode = 1; hit_result = 01.
- Render port: independent read port. TileCode is registered, 1-cycle latency from DrawX/DrawY.
- Render read and hit write to the same cell in the same cycle: the render port returns the old value.
- Reset (async): state=CLEAR, sweep index=0, base_destroyed=00, hit_done=0, hit_result=00, TileCode=0, busy=1, hit_ready=0, load_ready=0.
- CLEAR state:
  - Writes one cell per cycle, in index order 0..N-1 (N = MAP_W*MAP_H).
  - Edge cells get code 1; all other cells get code 0. HP is set to WALL_HP.
  - After writing index N-1, goes to IDLE; busy falls on the cycle IDLE is entered.
  - A clear takes exactly N cycles.
- clear_start in IDLE: enters CLEAR and clears base_destroyed. clear_start in any other state is ignored.
- IDLE state:
  - hit_ready = 1 and load_ready = 1.
  - hit_req has priority over load_we. If both are high, the hit is taken and the load is dropped.
  - Accepted load writes load_data at load_addr and sets HP to WALL_HP. load_addr >= N is ignored.
- HIT sequence (IDLE -> HIT_RD -> HIT_WR -> IDLE):
  - hit_x/hit_y are latched at acceptance.
  - HIT_RD reads the cell.
  - HIT_WR writes back and pulses hit_done with hit_result. hit_done is asserted 2 cycles after acceptance.
  - hit_ready and load_ready are 0 in HIT_RD and HIT_WR.
  - Code 0 -> result 00, no write.
  - Code 1 -> result 01, no write.
  - Code 2 -> per Optional Feature: result 10 (damaged) or 11 (destroyed, cell written to 0).
  - Code 3 or 4 -> result 11; cell written to 0; base_destroyed[code-3] set.
- base_destroyed is cleared only by reset or clear_start.
- Reset mid-hit or mid-clear aborts the operation: no hit_done pulse, and the sweep restarts from index 0.

Optional Feature:
- Macro: TILE_HP_EN.
- Defined:
  - Each cell stores a clog2(WALL_HP+1)-bit HP counter.
  - A hit on code 2 decrements HP. If HP after the decrement is 0, the cell becomes 0 and result = 11; otherwise result = 10.
  - HP reloads to WALL_HP on clear and on load writes.
- Undefined:
  - No HP storage.
  - A hit on code 2 always destroys the wall (result 11).
  - WALL_HP is ignored.

Test Plan:
- Reset, then wait: busy stays high for exactly 300 cycles. Afterwards, DrawX=0,DrawY=0 gives TileCode=1 and DrawX=40,DrawY=40 gives TileCode=0, each one cycle after the coordinates are applied.
- Load idx 21 with code 2; hit at (40,40), tile (1,1):
  - With TILE_HP_EN: first hit -> hit_done 2 cycles after acceptance with result 10; second hit -> 11; TileCode at (40,40) then reads 0.
  - Without TILE_HP_EN: first hit -> 11.
- Load idx 29 with code 4; hit at (290,40), tile (9,1) -> result 11, base_destroyed=10. A further hit on the same cell -> result 00 and the flag stays set.
- Hit at (700,100) -> result 01. Hit on border cell (0,0) -> result 01. Neither causes a write.
- hit_req and load_we asserted in the same IDLE cycle -> the hit completes and the load address is unchanged. load_ready=0 in HIT_RD and HIT_WR; a load_we there is dropped.
- Assert Reset_n low during HIT_RD -> no hit_done pulse, base flags cleared, clear sweep restarts. Then clear_start in IDLE -> busy high for 300 cycles and base_destroyed=00.
